// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: default datapath widths and the MEM/WB field bundle
// used by the stage registers at the default widths.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned RA_W_DEFAULT  = 5;
  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] aluResult;
    logic [XLEN_DEFAULT-1:0] memData;
    logic [RA_W_DEFAULT-1:0] rd;
    logic                    MemtoReg;
    logic                    RegWrite;
  } wb_fields_t;

endpackage

// File: rtl/wb_skid_buf.sv
// Generic valid/ready skid buffer with a main (output) entry and one skid entry.
// in_ready is a pure register output, so downstream back-pressure never reaches upstream combinationally.
module wb_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] main_r;
  logic [W-1:0] skid_r;
  logic         main_vld_r;
  logic         skid_vld_r;
  logic         acc_s;
  logic         take_s;

  assign in_ready  = ~skid_vld_r;
  assign out_valid = main_vld_r;
  assign out_data  = main_r;
  assign acc_s     = in_valid & ~skid_vld_r;
  assign take_s    = main_vld_r & out_ready;

  // Occupancy and entry update; the pair of valid bits is the whole state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_r     <= '0;
      skid_r     <= '0;
      main_vld_r <= 1'b0;
      skid_vld_r <= 1'b0;
    end else if (flush) begin
      // A take in this cycle still completes downstream; only the valids are dropped.
      main_vld_r <= 1'b0;
      skid_vld_r <= 1'b0;
    end else begin
      case ({main_vld_r, skid_vld_r})
        2'b00: begin
          if (acc_s) begin
            main_r     <= in_data;
            main_vld_r <= 1'b1;
          end
        end
        2'b10: begin
          if (acc_s && take_s) begin
            main_r <= in_data;
          end else if (acc_s) begin
            skid_r     <= in_data;
            skid_vld_r <= 1'b1;
          end else if (take_s) begin
            main_vld_r <= 1'b0;
          end
        end
        2'b11: begin
          if (take_s) begin
            main_r     <= skid_r;
            skid_vld_r <= 1'b0;
          end
        end
        default: begin
          main_vld_r <= 1'b0;
          skid_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline stage: skid-buffered handshake, register-file write port with x0
// suppression, and a retired-instruction counter.
module wb_stage_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned RA_W  = RA_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  aluResult_in,
  input  logic [XLEN-1:0]  memData_in,
  input  logic [RA_W-1:0]  rd_in,
  input  logic             MemtoReg_in,
  input  logic             RegWrite_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  aluResult_out,
  output logic [XLEN-1:0]  memData_out,
  output logic [RA_W-1:0]  rd_out,
  output logic             MemtoReg_out,
  output logic             RegWrite_out,
  output logic             wb_we,
  output logic [RA_W-1:0]  wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] retired
);

  // Same layout as wb_fields_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] memData;
    logic [RA_W-1:0] rd;
    logic            MemtoReg;
    logic            RegWrite;
  } fields_t;

  localparam int unsigned PW = $bits(fields_t);

  fields_t          in_fields_s;
  fields_t          out_fields_s;
  logic [PW-1:0]    out_data_s;
  logic             take_s;
  logic [CNT_W-1:0] retired_r;

  assign in_fields_s = '{aluResult: aluResult_in, memData: memData_in, rd: rd_in,
                         MemtoReg: MemtoReg_in, RegWrite: RegWrite_in};

  wb_skid_buf #(.W(PW)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_fields_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  assign out_fields_s  = fields_t'(out_data_s);
  assign aluResult_out = out_fields_s.aluResult;
  assign memData_out   = out_fields_s.memData;
  assign rd_out        = out_fields_s.rd;
  assign MemtoReg_out  = out_fields_s.MemtoReg;
  assign RegWrite_out  = out_fields_s.RegWrite;

  assign take_s  = out_valid & out_ready;
  assign wb_we   = take_s & RegWrite_out & (rd_out != {RA_W{1'b0}});
  assign wb_addr = rd_out;
  assign wb_data = MemtoReg_out ? memData_out : aluResult_out;
  assign retired = retired_r;

  // Retire counter: one per completed transfer, wraps naturally, survives flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_r <= '0;
    end else if (take_s) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: a 64-bit/32-bit-counter instance and a
// 32-bit/4-bit-counter instance driven with the same stimulus.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [63:0] aluResult_in;
  logic [63:0] memData_in;
  logic [4:0]  rd_in;
  logic        MemtoReg_in;
  logic        RegWrite_in;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, MemtoReg_out, RegWrite_out, wb_we;
  logic [63:0] aluResult_out, memData_out, wb_data;
  logic [4:0]  rd_out, wb_addr;
  logic [31:0] retired;

  logic        s_in_ready, s_out_valid, s_MemtoReg_out, s_RegWrite_out, s_wb_we;
  logic [31:0] s_aluResult_out, s_memData_out, s_wb_data;
  logic [4:0]  s_rd_out, s_wb_addr;
  logic [3:0]  s_retired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.XLEN(64), .RA_W(5), .CNT_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluResult_in(aluResult_in), .memData_in(memData_in), .rd_in(rd_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .aluResult_out(aluResult_out),
    .memData_out(memData_out), .rd_out(rd_out), .MemtoReg_out(MemtoReg_out),
    .RegWrite_out(RegWrite_out), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .retired(retired)
  );

  wb_stage_pipe #(.XLEN(32), .RA_W(5), .CNT_W(4)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .aluResult_in(aluResult_in[31:0]), .memData_in(memData_in[31:0]), .rd_in(rd_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .aluResult_out(s_aluResult_out),
    .memData_out(s_memData_out), .rd_out(s_rd_out), .MemtoReg_out(s_MemtoReg_out),
    .RegWrite_out(s_RegWrite_out), .wb_we(s_wb_we), .wb_addr(s_wb_addr),
    .wb_data(s_wb_data), .retired(s_retired)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [63:0] alu, input logic [63:0] mem,
                        input logic [4:0] rd, input logic m2r, input logic rw);
    in_valid     = v;
    aluResult_in = alu;
    memData_in   = mem;
    rd_in        = rd;
    MemtoReg_in  = m2r;
    RegWrite_in  = rw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
    #3;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_retired", {32'd0, retired}, 64'd0);
    check_eq("rst_alu", aluResult_out, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back, 4 instructions
    out_ready = 1'b1;
    set_in(1'b1, 64'h10, 64'h0, 5'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("b2b_out_valid", {63'd0, out_valid}, 64'd1);
      check_eq("b2b_wb_we", {63'd0, wb_we}, 64'd1);
      check_eq("b2b_wb_addr", {59'd0, wb_addr}, 64'(i + 1));
      check_eq("b2b_wb_data", wb_data, 64'(32'h10 + i));
      check_eq("b2b_small_data", {32'd0, s_wb_data}, 64'(32'h10 + i));
      if (i < 3) set_in(1'b1, 64'(32'h11 + i), 64'h0, 5'(i + 2), 1'b0, 1'b1);
      else in_valid = 1'b0;
    end
    tick();
    check_eq("b2b_drained", {63'd0, out_valid}, 64'd0);
    check_eq("b2b_retired", {32'd0, retired}, 64'd4);
    check_eq("b2b_small_retired", {60'd0, s_retired}, 64'd4);

    // Stall: out_ready low for three cycles with input offered
    out_ready = 1'b0;
    set_in(1'b1, 64'h20, 64'h0, 5'd5, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 64'h21, 64'h0, 5'd6, 1'b0, 1'b1);
    #1;
    check_eq("stall_ready_c1", {63'd0, in_ready}, 64'd1);
    check_eq("stall_no_we", {63'd0, wb_we}, 64'd0);
    tick();
    set_in(1'b1, 64'h22, 64'h0, 5'd7, 1'b0, 1'b1);
    #1;
    check_eq("stall_ready_c2", {63'd0, in_ready}, 64'd0);
    check_eq("stall_hold_c2", aluResult_out, 64'h20);
    tick();
    check_eq("stall_ready_c3", {63'd0, in_ready}, 64'd0);
    check_eq("stall_hold_c3", aluResult_out, 64'h20);
    check_eq("stall_valid_c3", {63'd0, out_valid}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("stall_we_a", {63'd0, wb_we}, 64'd1);
    check_eq("stall_data_a", wb_data, 64'h20);
    check_eq("stall_addr_a", {59'd0, wb_addr}, 64'd5);
    tick();
    check_eq("stall_ready_back", {63'd0, in_ready}, 64'd1);
    check_eq("stall_data_b", wb_data, 64'h21);
    check_eq("stall_we_b", {63'd0, wb_we}, 64'd1);
    tick();
    check_eq("stall_empty", {63'd0, out_valid}, 64'd0);
    check_eq("stall_retired", {32'd0, retired}, 64'd6);

    // Flush in TWO with a take and an incoming instruction
    out_ready = 1'b0;
    set_in(1'b1, 64'h30, 64'h0, 5'd8, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 64'h31, 64'h0, 5'd9, 1'b0, 1'b1);
    tick();
    check_eq("flush_two", {63'd0, in_ready}, 64'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 64'h32, 64'h0, 5'd10, 1'b0, 1'b1);
    #1;
    check_eq("flush_we", {63'd0, wb_we}, 64'd1);
    check_eq("flush_data", wb_data, 64'h30);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("flush_retired", {32'd0, retired}, 64'd7);

    // Flush in ONE while accepting and not taking: everything dropped
    out_ready = 1'b0;
    set_in(1'b1, 64'h38, 64'h0, 5'd3, 1'b0, 1'b1);
    tick();
    flush = 1'b1;
    set_in(1'b1, 64'h39, 64'h0, 5'd4, 1'b0, 1'b1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush1_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush1_retired", {32'd0, retired}, 64'd7);

    // x0 suppression and write-back mux
    out_ready = 1'b1;
    set_in(1'b1, 64'h40, 64'h0, 5'd0, 1'b0, 1'b1);
    tick();
    check_eq("x0_we", {63'd0, wb_we}, 64'd0);
    set_in(1'b1, 64'hBEEF, 64'hDEAD, 5'd11, 1'b1, 1'b1);
    tick();
    check_eq("mux_mem", wb_data, 64'hDEAD);
    check_eq("mux_mem_we", {63'd0, wb_we}, 64'd1);
    set_in(1'b1, 64'hBEEF, 64'hDEAD, 5'd11, 1'b0, 1'b1);
    tick();
    check_eq("mux_alu", wb_data, 64'hBEEF);
    check_eq("mux_alu_small", {32'd0, s_wb_data}, 64'hBEEF);
    set_in(1'b1, 64'h41, 64'h0, 5'd12, 1'b0, 1'b0);
    tick();
    check_eq("norw_we", {63'd0, wb_we}, 64'd0);
    in_valid = 1'b0;
    tick();
    check_eq("mux_retired", {32'd0, retired}, 64'd11);

    // Asynchronous reset while holding two entries
    out_ready = 1'b0;
    set_in(1'b1, 64'h50, 64'h0, 5'd12, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 64'h51, 64'h0, 5'd13, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check_eq("arst_pre_two", {63'd0, in_ready}, 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst_retired", {32'd0, retired}, 64'd0);
    check_eq("arst_alu", aluResult_out, 64'd0);
    check_eq("arst_rd", {59'd0, rd_out}, 64'd0);
    check_eq("arst_small_retired", {60'd0, s_retired}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // 17 takes: 4-bit counter wraps to 1
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 64'(32'h60 + i), 64'h0, 5'd1, 1'b0, 1'b1);
      tick();
    end
    check_eq("wrap_small_data", {32'd0, s_wb_data}, 64'h70);
    in_valid = 1'b0;
    tick();
    check_eq("wrap_small_retired", {60'd0, s_retired}, 64'd1);
    check_eq("wrap_retired", {32'd0, retired}, 64'd17);
    check_eq("wrap_small_empty", {63'd0, s_out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
